// File: rtl/keypad_emulator_if.sv
// rtl/keypad_emulator_if.sv - key-code valid/ready handshake into the keypad emulator
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - passive 4x4 hex keypad model replaying queued key presses
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 1000,
    parameter int BOUNCE_CYCLES = 0,
    parameter int BOUNCE_PERIOD = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          col_i,
    output logic [3:0]          row_o,
    keypad_emulator_if.slave    key_if,
    output logic                busy_o,
    output logic                contact_o,
    output logic                done_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
    localparam logic [23:0] HOLD_LOAD   = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] GAP_LOAD    = 24'(GAP_CYCLES - 1);
    localparam logic [23:0] BOUNCE_LOAD = 24'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [23:0] PERIOD_LOAD = 24'(BOUNCE_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_B_IN,
        S_HOLD,
        S_B_OUT,
        S_GAP
    } state_t;

    // ---------------- key queue ----------------
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, push, pop;

    assign full             = (count_q == CW'(FIFO_DEPTH));
    assign empty            = (count_q == '0);
    assign push             = key_if.key_valid && !full;
    assign key_if.key_ready = !full;

    // Queue storage; flushing is done through the pointers and count only
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= key_if.key_code;
        end
    end

    // Queue pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // ---------------- press sequencer ----------------
    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] phase_q, phase_d;
    logic        contact_q, contact_d;
    logic        busy_q;
    logic [3:0]  cur_key_q, cur_key_d;

    // Sequencer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            phase_q   <= '0;
            contact_q <= 1'b0;
            busy_q    <= 1'b0;
            cur_key_q <= 4'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            contact_q <= contact_d;
            busy_q    <= (state_d != S_IDLE);
            cur_key_q <= cur_key_d;
        end
    end

    // Next-state logic: each state entry reloads the shared down-counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        contact_d = contact_q;
        cur_key_d = cur_key_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                contact_d = 1'b0;
                if (!empty) begin
                    pop       = 1'b1;
                    cur_key_d = mem_q[rd_ptr_q];
                    contact_d = 1'b1;
                    if (HAS_BOUNCE) begin
                        state_d = S_B_IN;
                        cnt_d   = BOUNCE_LOAD;
                        phase_d = PERIOD_LOAD;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            S_B_IN, S_B_OUT: begin
                if (cnt_q == '0) begin
                    if (state_q == S_B_IN) begin
                        state_d   = S_HOLD;
                        cnt_d     = HOLD_LOAD;
                        contact_d = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        cnt_d     = GAP_LOAD;
                        contact_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                    if (phase_q == '0) begin
                        contact_d = !contact_q;
                        phase_d   = PERIOD_LOAD;
                    end else begin
                        phase_d = phase_q - 24'd1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    contact_d = 1'b0;
                    if (HAS_BOUNCE) begin
                        state_d = S_B_OUT;
                        cnt_d   = BOUNCE_LOAD;
                        phase_d = PERIOD_LOAD;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                contact_d = 1'b0;
            end
        endcase
    end

    assign busy_o    = busy_q;
    assign contact_o = contact_q;
    assign done_o    = (state_q == S_GAP) && (cnt_q == '0);

    // ---------------- row drive ----------------
    logic [1:0] kc, kr;

    // Key position: kc is the column bit that selects it, kr the row bit it pulls low
    always_comb begin
        kc = 2'd0;
        kr = 2'd0;
        case (cur_key_q)
            4'h1: begin kc = 2'd3; kr = 2'd3; end
            4'h4: begin kc = 2'd3; kr = 2'd2; end
            4'h7: begin kc = 2'd3; kr = 2'd1; end
            4'h0: begin kc = 2'd3; kr = 2'd0; end
            4'h2: begin kc = 2'd2; kr = 2'd3; end
            4'h5: begin kc = 2'd2; kr = 2'd2; end
            4'h8: begin kc = 2'd2; kr = 2'd1; end
            4'hF: begin kc = 2'd2; kr = 2'd0; end
            4'h3: begin kc = 2'd1; kr = 2'd3; end
            4'h6: begin kc = 2'd1; kr = 2'd2; end
            4'h9: begin kc = 2'd1; kr = 2'd1; end
            4'hE: begin kc = 2'd1; kr = 2'd0; end
            4'hA: begin kc = 2'd0; kr = 2'd3; end
            4'hB: begin kc = 2'd0; kr = 2'd2; end
            4'hC: begin kc = 2'd0; kr = 2'd1; end
            4'hD: begin kc = 2'd0; kr = 2'd0; end
            default: begin kc = 2'd0; kr = 2'd0; end
        endcase
    end

    // Rows follow the scanner's columns with no register in the path
    always_comb begin
        row_o = 4'b1111;
        if (contact_q && !col_i[kc]) begin
            row_o[kr] = 1'b0;
        end
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Emulates a passive 4x4 hex keypad on the far side of the row/column scan interface: the scanner drives one column low at a time, and this block pulls the row of the currently pressed key low. Hex key codes are queued on a valid/ready port and replayed as timed presses with optional contact bounce, ending with a release gap. Used in simulation benches and on-board loopback (JA wired to a second PMOD) to exercise the keypad decoder and display path without a physical keypad.

## Interface
- HOLD_CYCLES, 1000: stable-closed contact time per press, in clk cycles (≥1)
- GAP_CYCLES, 1000: open time after each press before the next key is taken (≥1)
- BOUNCE_CYCLES, 0: length of each bounce window, at make and at break (0 = no bounce)
- BOUNCE_PERIOD, 4: contact toggle interval inside a bounce window (≥1)
- FIFO_DEPTH, 4: key queue depth (power of two)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- col  in  4  column drive from scanner, active low (JA[3:0] side)
- row  out  4  row sense to scanner, active low (JA[7:4] side)
- key_code  in  4  hex key to press
- key_valid  in  1  key_code is offered
- key_ready  out  1  queue can accept (not full)
- busy  out  1  press sequence in progress (state ≠ IDLE)
- contact  out  1  current contact state (1 = closed)
- done  out  1  one-cycle pulse when a press sequence finishes

## Operation
- Key map, as column → keys in rows 0..3, with row r low giving row[3-r]=0:
  - col=0111: 1, 4, 7, 0
  - col=1011: 2, 5, 8, F
  - col=1101: 3, 6, 9, E
  - col=1110: A, B, C, D
- row is combinational from col, contact, and the registered current key: row[kr]=0 iff contact=1 and col[kc]=0; all other bits are 1. Any number of low columns is legal.
- Queue: push on key_valid & key_ready. key_ready = !full. There is no push while full; key_valid is held by the source.
- FSM states: IDLE, B_IN, HOLD, B_OUT, GAP.
  - IDLE: if the queue is non-empty, pop into cur_key and go to B_IN (or to HOLD if BOUNCE_CYCLES=0).
  - B_IN lasts BOUNCE_CYCLES cycles. contact=1 on the first cycle and inverts every BOUNCE_PERIOD cycles. Then go to HOLD.
  - HOLD: contact=1 for HOLD_CYCLES cycles, then go to B_OUT (or to GAP if BOUNCE_CYCLES=0).
  - B_OUT lasts BOUNCE_CYCLES cycles. contact=0 on the first cycle and inverts every BOUNCE_PERIOD cycles. Then go to GAP.
  - GAP: contact=0 for GAP_CYCLES cycles. On the last cycle, done=1 and go to IDLE.
- One shared 24-bit down-counter is loaded on each state entry. A separate bounce-phase counter is used in the bounce states.
- Reset (asynchronous, any state):
  - FSM to IDLE, queue flushed, cur_key=0.
  - contact=0, so row=1111 immediately.
  - busy=0, done=0, key_ready=1.

## Timing
- A push accepted at edge T into an empty queue: FSM leaves IDLE at edge T+1, and contact=1 is visible after edge T+1.
- Total press length = 2·BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES cycles, plus 1 IDLE cycle before the next pop.
- contact and busy are registered. row has zero-cycle latency from col.
- Back-to-back queued keys: IDLE dwells exactly 1 cycle between done and the next contact=1.
- A push and a pop in the same cycle are legal. The count is unchanged and key_ready does not glitch.
- Reset mid-press aborts the press with no done pulse.

## Test plan
- Reset: rst_n=0 with col toggling → row=1111, key_ready=1, busy=0, contact=0. Release reset → no activity while the queue is empty.
- Single press, HOLD=4, GAP=2, BOUNCE=0, push key 5, scanner cycling col 0111→1011→1101→1110 → row=1011 only while col=1011, for exactly 4 cycles of contact=1. Then done pulses 2 cycles after contact falls. Total busy=6.
- Full map: col held at 0000, push each code 0..F in turn → row matches the key map (e.g. 0→1110, F→1110 on col 1011; 1→0111; D→1110). With col=1111, row=1111 always.
- Queue full, FIFO_DEPTH=4, push 6 keys back to back from idle → key_ready falls after the 5th accept (one popped at T+1). Keys are pressed in push order with exactly one IDLE cycle between presses.
- Bounce, BOUNCE=6, PERIOD=2, HOLD=3, GAP=1 → contact sequence 1,1,0,0,1,1 | 1,1,1 | 0,0,1,1,0,0 | 0, then done.
- Reset mid-HOLD with key 9 and col=1101 (row=1101) → row becomes 1111 asynchronously, the queue is empty, no done pulse. The next push restarts cleanly.
